// File: rtl/divergent_scheduler_if.sv
// divergent_scheduler_if
//   Control bundle between a core's scheduler and the rest of the core
//   (fetcher, decoder, LSUs, per-thread PC units).
//   master : scheduler side (drives current_pc, active_mask, core_state, done)
//   slave  : core side (drives start, thread_count, decoded_*, fetcher_state,
//            lsu_state, next_pc)
//   lsu_state : 2 bits per thread, thread i at [2i+1:2i]
//   next_pc   : PC_WIDTH bits per thread, thread i at [i*PC_WIDTH +: PC_WIDTH]
interface divergent_scheduler_if #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8
);
  localparam int TCW = $clog2(THREADS_PER_BLOCK) + 1;

  logic                                  start;
  logic [TCW-1:0]                        thread_count;
  logic                                  decoded_mem_read_enable;
  logic                                  decoded_mem_write_enable;
  logic                                  decoded_ret;
  logic [2:0]                            fetcher_state;
  logic [2*THREADS_PER_BLOCK-1:0]        lsu_state;
  logic [PC_WIDTH*THREADS_PER_BLOCK-1:0] next_pc;
  logic [PC_WIDTH-1:0]                   current_pc;
  logic [THREADS_PER_BLOCK-1:0]          active_mask;
  logic [2:0]                            core_state;
  logic                                  done;

  modport master (
    input  start, thread_count, decoded_mem_read_enable, decoded_mem_write_enable,
           decoded_ret, fetcher_state, lsu_state, next_pc,
    output current_pc, active_mask, core_state, done
  );

  modport slave (
    output start, thread_count, decoded_mem_read_enable, decoded_mem_write_enable,
           decoded_ret, fetcher_state, lsu_state, next_pc,
    input  current_pc, active_mask, core_state, done
  );
endinterface

// File: rtl/divergent_scheduler.sv
// divergent_scheduler
//   Per-core control FSM with branch-divergence handling. Every thread keeps
//   its own PC and retire flag; each instruction issues to the live threads
//   sitting at the minimum PC, so diverged paths reconverge by themselves.
//   Ports:
//     clk, reset      : clock, synchronous active-high reset
//     bus (master)    : divergent_scheduler_if control bundle
//     cycle_count,
//     instr_count,
//     diverge_count   : saturating 32-bit perf counters (SCHED_PERF_EN only)
//   Build option: define SCHED_PERF_EN to include the performance counters.
//
// divergent_scheduler_lane
//   Per-thread PC / retire state. pc_upd and retired_upd are the values the
//   lane takes if the current cycle is UPDATE; the top uses them to pick the
//   next issue group in the same cycle.

module divergent_scheduler_lane #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                launch,
  input  logic                update,
  input  logic                active,
  input  logic                ret,
  input  logic [PC_WIDTH-1:0] next_pc,
  output logic [PC_WIDTH-1:0] pc_upd,
  output logic                retired_upd
);
  logic [PC_WIDTH-1:0] pc_q;
  logic                retired_q;

  assign pc_upd      = (active && !ret) ? next_pc : pc_q;
  assign retired_upd = retired_q | (active & ret);

  always_ff @(posedge clk) begin
    if (reset || launch) begin
      pc_q      <= '0;
      retired_q <= 1'b0;
    end else if (update) begin
      pc_q      <= pc_upd;
      retired_q <= retired_upd;
    end
  end
endmodule

module divergent_scheduler #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  divergent_scheduler_if.master bus
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [31:0]           instr_count,
  output logic [31:0]           diverge_count
`endif
);
  localparam int T = THREADS_PER_BLOCK;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } state_t;

  state_t                     state_q, state_d;
  logic [T-1:0]               enabled, busy, live_upd, retired_upd, new_mask;
  logic [T-1:0][PC_WIDTH-1:0] pc_upd;
  logic [PC_WIDTH-1:0]        minpc, current_pc_q;
  logic [T-1:0]               mask_q;
  logic                       done_q, launch, do_update, any_live;

  // Load/store kind is decoded upstream but does not steer the FSM.
  logic unused_mem_flags;
  assign unused_mem_flags = bus.decoded_mem_read_enable ^ bus.decoded_mem_write_enable;

  always_comb begin
    enabled = '0;
    busy    = '0;
    for (int i = 0; i < T; i++) begin
      enabled[i] = int'(bus.thread_count) > i;
      // Only threads issuing the current instruction can stall WAIT.
      busy[i]    = mask_q[i] && (bus.lsu_state[2*i +: 2] == 2'b01 ||
                                 bus.lsu_state[2*i +: 2] == 2'b10);
    end
  end

  for (genvar g = 0; g < T; g++) begin : g_lane
    divergent_scheduler_lane #(.PC_WIDTH(PC_WIDTH)) u_lane (
      .clk         (clk),
      .reset       (reset),
      .launch      (launch),
      .update      (do_update),
      .active      (mask_q[g]),
      .ret         (bus.decoded_ret),
      .next_pc     (bus.next_pc[g*PC_WIDTH +: PC_WIDTH]),
      .pc_upd      (pc_upd[g]),
      .retired_upd (retired_upd[g])
    );
  end

  // Issue-group selection on post-UPDATE values: lowest PC among live threads.
  assign live_upd = enabled & ~retired_upd;
  assign any_live = |live_upd;

  always_comb begin
    minpc    = '1;
    new_mask = '0;
    for (int i = 0; i < T; i++)
      if (live_upd[i] && pc_upd[i] < minpc) minpc = pc_upd[i];
    for (int i = 0; i < T; i++)
      new_mask[i] = live_upd[i] && (pc_upd[i] == minpc);
  end

  always_comb begin
    state_d   = state_q;
    launch    = 1'b0;
    do_update = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.thread_count == '0) state_d = DONE;
        else begin
          state_d = FETCH;
          launch  = 1'b1;
        end
      end
      FETCH:   if (bus.fetcher_state == 3'b010) state_d = DECODE;
      DECODE:  state_d = REQUEST;
      REQUEST: state_d = WAIT;
      WAIT:    if (!(|busy)) state_d = EXECUTE;
      EXECUTE: state_d = UPDATE;
      UPDATE: begin
        do_update = 1'b1;
        state_d   = any_live ? FETCH : DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      current_pc_q <= '0;
      mask_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        current_pc_q <= '0;
        mask_q       <= enabled;
      end
      // When every thread has retired, pc/mask keep their last values.
      if (do_update && any_live) begin
        current_pc_q <= minpc;
        mask_q       <= new_mask;
      end
      if (state_d == DONE) done_q <= 1'b1;
    end
  end

  assign bus.current_pc  = current_pc_q;
  assign bus.active_mask = mask_q;
  assign bus.core_state  = state_q;
  assign bus.done        = done_q;

`ifdef SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count   <= '0;
      instr_count   <= '0;
      diverge_count <= '0;
    end else begin
      if (state_q != IDLE && state_q != DONE && cycle_count != '1)
        cycle_count <= cycle_count + 32'd1;
      if (do_update && instr_count != '1)
        instr_count <= instr_count + 32'd1;
      // Divergence: some live thread is left out of the next issue group.
      if (do_update && any_live && new_mask != live_upd && diverge_count != '1)
        diverge_count <= diverge_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_divergent_scheduler.sv
module tb_divergent_scheduler;
  localparam int T   = 4;
  localparam int PW  = 8;
  localparam int TCW = $clog2(T) + 1;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_REQUEST = 3'd3,
                         ST_WAIT = 3'd4, ST_DONE = 3'd7;

  typedef struct {
    logic [PW-1:0] pc;
    logic [T-1:0]  mask;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  divergent_scheduler_if #(.THREADS_PER_BLOCK(T), .PC_WIDTH(PW)) bus ();

`ifdef SCHED_PERF_EN
  logic [31:0] cycle_count, instr_count, diverge_count;
`endif

  divergent_scheduler #(.THREADS_PER_BLOCK(T), .PC_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SCHED_PERF_EN
    ,
    .cycle_count   (cycle_count),
    .instr_count   (instr_count),
    .diverge_count (diverge_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  exp_t sb[$];

  // Program / environment knobs.
  int            prog = 0;
  logic [PW-1:0] ret_a = 8'd3, ret_b = 8'hFF;
  int            fetch_delay = 0;
  int            busy_pc = -1;
  logic          hold3 = 1'b0;

  // Observations.
  logic [2:0] prev_st = ST_IDLE;
  int         wait_run = 0, min_wait = 1000, max_wait = 0;
  logic       saw_fetch = 1'b0;
  int         fwait = 0, busy_left = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [PW-1:0] pc, input logic [T-1:0] mask);
    exp_t e;
    e.pc = pc;
    e.mask = mask;
    sb.push_back(e);
  endtask

  // Instruction stream seen by the scheduler, keyed on current_pc.
  always_comb begin
    bus.decoded_ret = (bus.current_pc == ret_a) || (bus.current_pc == ret_b);
    bus.next_pc = '0;
    for (int i = 0; i < T; i++) begin
      bus.next_pc[i*PW +: PW] = bus.current_pc + 8'd1;
      if (bus.current_pc == 8'd1 && prog == 1)
        bus.next_pc[i*PW +: PW] = (i < 2) ? 8'd5 : 8'd3;
      if (bus.current_pc == 8'd1 && prog == 2)
        bus.next_pc[i*PW +: PW] = (i == 0) ? 8'd2 : 8'd3;
    end
  end

  // Fetcher and LSU responders, driven away from the active edge.
  always @(negedge clk) begin
    logic [2*T-1:0] lsu;
    if (bus.core_state == ST_FETCH) begin
      if (fwait > 0) begin
        bus.fetcher_state = 3'b000;
        fwait--;
      end else bus.fetcher_state = 3'b010;
    end else begin
      bus.fetcher_state = 3'b000;
      fwait = fetch_delay;
    end
    lsu = '0;
    if (hold3) lsu[7:6] = 2'b10;
    if (bus.core_state == ST_REQUEST && int'(bus.current_pc) == busy_pc) busy_left = 3;
    if (bus.core_state == ST_WAIT && busy_left > 0) begin
      lsu[3:2] = 2'b01;
      busy_left--;
    end
    bus.lsu_state = lsu;
  end

  // Scoreboard: each entry into FETCH is one issued instruction.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.core_state == ST_FETCH && prev_st != ST_FETCH) begin
      saw_fetch = 1'b1;
      if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("issue_pc", 64'(bus.current_pc), 64'(e.pc));
        chk("issue_mask", 64'(bus.active_mask), 64'(e.mask));
      end
    end
    if (bus.core_state == ST_WAIT) wait_run++;
    else if (prev_st == ST_WAIT) begin
      if (wait_run < min_wait) min_wait = wait_run;
      if (wait_run > max_wait) max_wait = wait_run;
      wait_run = 0;
    end
    prev_st = bus.core_state;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    min_wait = 1000;
    max_wait = 0;
    wait_run = 0;
  endtask

  // Launch a block and count edges from the IDLE exit until done is seen.
  task automatic run_block(input logic [TCW-1:0] tc, output int edges);
    @(negedge clk);
    bus.thread_count = tc;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    edges = 0;
    while (!bus.done && edges < 400) begin
      @(posedge clk);
      #1 edges++;
    end
  endtask

  task automatic push_uniform(input logic [T-1:0] m);
    for (int p = 0; p < 4; p++) push_exp(PW'(p), m);
  endtask

  initial begin
    int edges;
    bus.start = 1'b0;
    bus.thread_count = TCW'(4);
    bus.decoded_mem_read_enable = 1'b0;
    bus.decoded_mem_write_enable = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 64'(bus.core_state), 64'(ST_IDLE));
    chk("rst_pc", 64'(bus.current_pc), 64'd0);
    chk("rst_mask", 64'(bus.active_mask), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
`ifdef SCHED_PERF_EN
    chk("rst_cycles", 64'(cycle_count), 64'd0);
`endif
    reset = 1'b0;

    // Uniform program, RET at PC 3.
    prog = 0; ret_a = 8'd3; ret_b = 8'hFF;
    push_uniform(4'b1111);
    run_block(TCW'(4), edges);
    chk("uni_latency", 64'(edges), 64'd24);
    chk("uni_sb_left", 64'(sb.size()), 64'd0);
    chk("uni_wait_max", 64'(max_wait), 64'd1);
`ifdef SCHED_PERF_EN
    chk("uni_instr", 64'(instr_count), 64'd4);
    chk("uni_cycles", 64'(cycle_count), 64'd24);
    chk("uni_div", 64'(diverge_count), 64'd0);
`endif

    // Divergence at PC 1, reconvergence at PC 5.
    do_reset();
    prog = 1; ret_a = 8'd5;
    push_exp(8'd0, 4'b1111); push_exp(8'd1, 4'b1111);
    push_exp(8'd3, 4'b1100); push_exp(8'd4, 4'b1100);
    push_exp(8'd5, 4'b1111);
    run_block(TCW'(4), edges);
    chk("div_latency", 64'(edges), 64'd30);
    chk("div_sb_left", 64'(sb.size()), 64'd0);
`ifdef SCHED_PERF_EN
    chk("div_instr", 64'(instr_count), 64'd5);
    chk("div_count", 64'(diverge_count), 64'd2);
`endif

    // Partial block: disabled thread 3 busy, slow fetch, thread 1 LSU busy at PC 2.
    do_reset();
    prog = 0; ret_a = 8'd3; hold3 = 1'b1; fetch_delay = 2; busy_pc = 2;
    push_uniform(4'b0011);
    run_block(TCW'(2), edges);
    chk("part_latency", 64'(edges), 64'd35);
    chk("part_sb_left", 64'(sb.size()), 64'd0);
    chk("part_wait_min", 64'(min_wait), 64'd1);
    chk("part_wait_max", 64'(max_wait), 64'd4);
`ifdef SCHED_PERF_EN
    chk("part_cycles", 64'(cycle_count), 64'd35);
    chk("part_div", 64'(diverge_count), 64'd0);
`endif
    hold3 = 1'b0; fetch_delay = 0; busy_pc = -1;

    // Staggered RET: thread 0 returns at PC 2, the rest at PC 4.
    do_reset();
    prog = 2; ret_a = 8'd2; ret_b = 8'd4;
    push_exp(8'd0, 4'b1111); push_exp(8'd1, 4'b1111);
    push_exp(8'd2, 4'b0001); push_exp(8'd3, 4'b1110);
    push_exp(8'd4, 4'b1110);
    run_block(TCW'(4), edges);
    chk("stag_latency", 64'(edges), 64'd30);
    chk("stag_sb_left", 64'(sb.size()), 64'd0);
`ifdef SCHED_PERF_EN
    chk("stag_div", 64'(diverge_count), 64'd1);
`endif
    ret_b = 8'hFF;

    // Empty block goes straight to DONE; start is ignored there.
    do_reset();
    saw_fetch = 1'b0;
    bus.thread_count = '0;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("empty_state", 64'(bus.core_state), 64'(ST_DONE));
    chk("empty_done", 64'(bus.done), 64'd1);
    @(negedge clk);
    bus.thread_count = TCW'(4);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    chk("done_sticky", 64'(bus.core_state), 64'(ST_DONE));
    @(negedge clk);
    chk("empty_no_fetch", 64'(saw_fetch), 64'd0);

    // Reset in WAIT, then rerun from PC 0.
    do_reset();
    prog = 0; ret_a = 8'd3;
    push_uniform(4'b1111);
    bus.thread_count = TCW'(4);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 0; k < 50 && bus.core_state != ST_WAIT; k++) @(negedge clk);
    chk("reach_wait", 64'(bus.core_state), 64'(ST_WAIT));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rw_state", 64'(bus.core_state), 64'(ST_IDLE));
    chk("rw_pc", 64'(bus.current_pc), 64'd0);
    chk("rw_mask", 64'(bus.active_mask), 64'd0);
    chk("rw_done", 64'(bus.done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    push_uniform(4'b1111);
    run_block(TCW'(4), edges);
    chk("rerun_latency", 64'(edges), 64'd24);
    chk("rerun_sb_left", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
